// File: rtl/dmem_cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_cache_ctrl_pkg
// Description : Shared memory-system definitions. Holds the cache line
//               geometry, the default memory read latency, the controller
//               state encoding and a helper that builds a word address
//               from tag, index and word number.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_cache_ctrl_pkg;

   localparam int TAG_W       = 5;
   localparam int IDX_W       = 8;
   localparam int WORDS       = 4;
   localparam int WORD_W      = $clog2(WORDS);
   localparam int MEM_LAT_DEF = 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WB    = 3'd1,
      S_ALLOC = 3'd2,
      S_FILL  = 3'd3,
      S_RETRY = 3'd4
   } state_t;

   // Byte address of word k of a line; words sit on even byte offsets.
   function automatic logic [15:0] word_addr(input logic [TAG_W-1:0]  tag,
                                             input logic [IDX_W-1:0]  idx,
                                             input logic [WORD_W-1:0] k);
      return {tag, idx, k, 1'b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_cache_ctrl_fill_tracker.sv
`default_nettype none
// ============================================================================
// Module      : fill_tracker
// Description : MEM_LAT-deep shift register of outstanding memory read word
//               indices. A word pushed when its read is accepted pops out
//               exactly MEM_LAT cycles later, in the cycle its data returns.
// Ports       : clk, rst (async, active-low)
//               push, push_k    - read accepted this cycle and its word index
//               pop_valid, pop_k - returning word this cycle and its index
// Revision    : 1.0 - initial release
// ============================================================================
module fill_tracker
   import dmem_cache_ctrl_pkg::*;
#(
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [WORD_W-1:0] push_k,
   output logic              pop_valid,
   output logic [WORD_W-1:0] pop_k
);

   logic [MEM_LAT-1:0]             vld_q, vld_d;
   logic [MEM_LAT-1:0][WORD_W-1:0] k_q, k_d;

   always_comb begin
      vld_d    = '0;
      k_d      = '0;
      vld_d[0] = push;
      k_d[0]   = push_k;
      for (int i = 1; i < MEM_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         k_d[i]   = k_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         k_q   <= '0;
      end else begin
         vld_q <= vld_d;
         k_q   <= k_d;
      end
   end

   assign pop_valid = vld_q[MEM_LAT-1];
   assign pop_k     = k_q[MEM_LAT-1];

endmodule
`default_nettype wire

// File: rtl/dmem_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_cache_ctrl
// Description : Data-memory cache controller between the EX/MEM stage and an
//               external direct-mapped cache array plus banked memory.
//               Hits complete in the request cycle; misses write back a dirty
//               victim, stream four reads, fill the line as words return and
//               then retry the compare access.
// Ports       : clk, rst (async, active-low)
//               Addr/DataIn/Rd/Wr            - request from EX/MEM
//               DataOut/Done/Dmem_Stall/CacheHit/Err - pipeline status
//               c_*  - cache array control (out) and status (in)
//               m_*  - memory control (out) and status (in)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_cache_ctrl
   import dmem_cache_ctrl_pkg::*;
#(
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      Addr,
   input  logic [15:0]      DataIn,
   input  logic             Rd,
   input  logic             Wr,
   output logic [15:0]      DataOut,
   output logic             Done,
   output logic             Dmem_Stall,
   output logic             CacheHit,
   output logic             Err,
   output logic             c_enable,
   output logic             c_comp,
   output logic             c_write,
   output logic             c_valid_in,
   output logic [TAG_W-1:0] c_tag,
   output logic [IDX_W-1:0] c_index,
   output logic [2:0]       c_offset,
   output logic [15:0]      c_data_in,
   input  logic             c_hit,
   input  logic             c_dirty,
   input  logic             c_valid,
   input  logic [TAG_W-1:0] c_tag_out,
   input  logic [15:0]      c_data_out,
   output logic [15:0]      m_addr,
   output logic [15:0]      m_data_in,
   output logic             m_rd,
   output logic             m_wr,
   input  logic [15:0]      m_data_out,
   input  logic             m_stall
);

   state_t            state_q, state_d;
   logic [WORD_W-1:0] k_q, k_d;       // write-back / read-issue word counter
   logic [WORD_W-1:0] ret_q, ret_d;   // returned-word counter
   logic [15:0]       addr_q, addr_d;
   logic [15:0]       data_q, data_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;

   logic              w_req;
   logic              w_err;
   logic              w_hit;
   logic              w_push;
   logic              w_ret_valid;
   logic [WORD_W-1:0] w_ret_k;

   assign w_req  = Rd | Wr;
   assign w_err  = (Rd & Wr) | (w_req & Addr[0]);
   assign w_hit  = c_hit & c_valid;
   assign w_push = (state_q == S_ALLOC) & ~m_stall;

   fill_tracker #(
      .MEM_LAT (MEM_LAT)
   ) u_fill_tracker (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_k    (k_q),
      .pop_valid (w_ret_valid),
      .pop_k     (w_ret_k)
   );

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         ret_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         ret_q   <= ret_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      ret_d   = ret_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rd_d    = rd_q;
      wr_d    = wr_q;

      // Returns overlap the tail of ALLOC, so they are counted in any state.
      if (w_ret_valid) begin
         ret_d = ret_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (w_req && !w_err && !w_hit) begin
               addr_d  = Addr;
               data_d  = DataIn;
               rd_d    = Rd;
               wr_d    = Wr;
               k_d     = '0;
               ret_d   = '0;
               state_d = (c_valid && c_dirty) ? S_WB : S_ALLOC;
            end
         end
         S_WB: begin
            if (!m_stall) begin
               k_d = k_q + 1'b1;
               if (k_q == WORD_W'(WORDS - 1)) begin
                  state_d = S_ALLOC;
               end
            end
         end
         S_ALLOC: begin
            if (!m_stall) begin
               k_d = k_q + 1'b1;
               if (k_q == WORD_W'(WORDS - 1)) begin
                  state_d = S_FILL;
               end
            end
         end
         S_FILL: begin
            // The last return always lands after the last issue, i.e. here.
            if (w_ret_valid && ret_q == WORD_W'(WORDS - 1)) begin
               state_d = S_RETRY;
            end
         end
         S_RETRY: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------- outputs
   always_comb begin
      DataOut    = '0;
      Done       = 1'b0;
      Dmem_Stall = 1'b0;
      CacheHit   = 1'b0;
      Err        = 1'b0;
      c_enable   = 1'b0;
      c_comp     = 1'b0;
      c_write    = 1'b0;
      c_valid_in = 1'b0;
      c_tag      = '0;
      c_index    = '0;
      c_offset   = '0;
      c_data_in  = '0;
      m_addr     = '0;
      m_data_in  = '0;
      m_rd       = 1'b0;
      m_wr       = 1'b0;

      // Outputs are gated by reset so they drop without waiting for a clock.
      if (rst) begin
         case (state_q)
            S_IDLE: begin
               if (w_req) begin
                  if (w_err) begin
                     Err = 1'b1;
                  end else begin
                     c_enable   = 1'b1;
                     c_comp     = 1'b1;
                     c_write    = Wr;
                     c_valid_in = Wr;
                     c_tag      = Addr[15:11];
                     c_index    = Addr[10:3];
                     c_offset   = Addr[2:0];
                     c_data_in  = DataIn;
                     if (w_hit) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        DataOut  = Rd ? c_data_out : 16'h0;
                     end else begin
                        Dmem_Stall = 1'b1;
                     end
                  end
               end
            end
            S_WB: begin
               Dmem_Stall = 1'b1;
               c_enable   = 1'b1;
               c_tag      = addr_q[15:11];
               c_index    = addr_q[10:3];
               c_offset   = {k_q, 1'b0};
               m_wr       = 1'b1;
               m_addr     = word_addr(c_tag_out, addr_q[10:3], k_q);
               m_data_in  = c_data_out;
            end
            S_ALLOC: begin
               Dmem_Stall = 1'b1;
               m_rd       = 1'b1;
               m_addr     = word_addr(addr_q[15:11], addr_q[10:3], k_q);
            end
            S_FILL: begin
               Dmem_Stall = 1'b1;
            end
            S_RETRY: begin
               Done       = 1'b1;
               c_enable   = 1'b1;
               c_comp     = 1'b1;
               c_write    = wr_q;
               c_valid_in = wr_q;
               c_tag      = addr_q[15:11];
               c_index    = addr_q[10:3];
               c_offset   = addr_q[2:0];
               c_data_in  = data_q;
               DataOut    = rd_q ? c_data_out : 16'h0;
            end
            default: begin
            end
         endcase

         // Line fill: the cache port is otherwise idle in ALLOC and FILL.
         if (w_ret_valid && (state_q == S_ALLOC || state_q == S_FILL)) begin
            c_enable   = 1'b1;
            c_comp     = 1'b0;
            c_write    = 1'b1;
            c_valid_in = 1'b1;
            c_tag      = addr_q[15:11];
            c_index    = addr_q[10:3];
            c_offset   = {w_ret_k, 1'b0};
            c_data_in  = m_data_out;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_cache_ctrl
// Description : Self-checking bench for dmem_cache_ctrl. Provides a cache
//               array and latency-pipelined memory around the controller and
//               keeps a flat reference memory: every read must return the
//               last value written, with miss latency derived from line
//               state (clean / dirty) and injected memory stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_cache_ctrl;

   localparam int MEM_LAT = 2;
   localparam int CLEAN_LAT = 4 + MEM_LAT + 1;
   localparam int DIRTY_LAT = 8 + MEM_LAT + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] Addr, DataIn;
   logic        Rd, Wr;
   logic [15:0] DataOut;
   logic        Done, Dmem_Stall, CacheHit, Err;
   logic        c_enable, c_comp, c_write, c_valid_in;
   logic [4:0]  c_tag;
   logic [7:0]  c_index;
   logic [2:0]  c_offset;
   logic [15:0] c_data_in;
   logic        c_hit, c_dirty, c_valid;
   logic [4:0]  c_tag_out;
   logic [15:0] c_data_out;
   logic [15:0] m_addr, m_data_in;
   logic        m_rd, m_wr;
   logic [15:0] m_data_out;
   logic        m_stall;

   dmem_cache_ctrl #(.MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
      .DataOut(DataOut), .Done(Done), .Dmem_Stall(Dmem_Stall), .CacheHit(CacheHit), .Err(Err),
      .c_enable(c_enable), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
      .c_tag(c_tag), .c_index(c_index), .c_offset(c_offset), .c_data_in(c_data_in),
      .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out),
      .c_data_out(c_data_out), .m_addr(m_addr), .m_data_in(m_data_in), .m_rd(m_rd),
      .m_wr(m_wr), .m_data_out(m_data_out), .m_stall(m_stall)
   );

   // ------------------------------------------------------ cache array model
   logic [4:0]  ct   [256];
   logic        cv   [256];
   logic        cd   [256];
   logic [15:0] cdat [256][4];
   logic        pl_en, pl_dirty, env_clr;
   logic [7:0]  pl_idx;
   logic [4:0]  pl_tag;
   logic [15:0] pl_data [4];

   assign c_tag_out  = ct[c_index];
   assign c_valid    = cv[c_index];
   assign c_dirty    = cd[c_index];
   assign c_data_out = cdat[c_index][c_offset[2:1]];
   assign c_hit      = cv[c_index] && (ct[c_index] == c_tag);

   always @(posedge clk) begin
      if (env_clr) begin
         for (int i = 0; i < 256; i++) begin
            cv[i] <= 1'b0; cd[i] <= 1'b0; ct[i] <= '0;
            for (int k = 0; k < 4; k++) cdat[i][k] <= '0;
         end
      end else if (pl_en) begin
         ct[pl_idx] <= pl_tag; cv[pl_idx] <= 1'b1; cd[pl_idx] <= pl_dirty;
         for (int k = 0; k < 4; k++) cdat[pl_idx][k] <= pl_data[k];
      end else if (c_enable && c_write) begin
         if (c_comp) begin
            if (cv[c_index] && ct[c_index] == c_tag) begin
               cdat[c_index][c_offset[2:1]] <= c_data_in;
               cd[c_index] <= 1'b1;
            end
         end else begin
            cdat[c_index][c_offset[2:1]] <= c_data_in;
            ct[c_index] <= c_tag; cv[c_index] <= c_valid_in; cd[c_index] <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------ memory model
   logic [15:0] mem [int];
   logic [15:0] pd [MEM_LAT];
   logic [15:0] rd_log [$];
   logic [31:0] wr_log [$];
   logic        pl_mem_en;
   logic [14:0] pl_mem_a;
   logic [15:0] pl_mem_d;

   function automatic logic [15:0] init_val(input logic [14:0] w);
      logic [15:0] t;
      t = {1'b0, w} * 16'h9E37;
      return t ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] mem_rd(input logic [14:0] w);
      if (mem.exists(int'(w))) return mem[int'(w)];
      return init_val(w);
   endfunction

   assign m_data_out = pd[MEM_LAT-1];

   always @(posedge clk) begin
      pd[0] <= (m_rd && !m_stall) ? mem_rd(m_addr[15:1]) : 16'h0;
      for (int i = 1; i < MEM_LAT; i++) pd[i] <= pd[i-1];
      if (pl_mem_en) mem[int'(pl_mem_a)] = pl_mem_d;
      if (m_rd && !m_stall) rd_log.push_back(m_addr);
      if (m_wr && !m_stall) begin
         mem[int'(m_addr[15:1])] = m_data_in;
         wr_log.push_back({m_addr, m_data_in});
      end
   end

   // ------------------------------------------------------- reference memory
   logic [15:0] ref_mem [int];

   function automatic logic [15:0] ref_rd(input logic [15:0] a);
      if (ref_mem.exists(int'(a[15:1]))) return ref_mem[int'(a[15:1])];
      return init_val(a[15:1]);
   endfunction

   // --------------------------------------------------------------- checking
   int n_checks;
   int n_errors;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic any_out();
      return |{DataOut, Done, Dmem_Stall, CacheHit, Err, c_enable, c_comp, c_write,
               c_valid_in, c_tag, c_index, c_offset, c_data_in, m_addr, m_data_in, m_rd, m_wr};
   endfunction

   // ------------------------------------------------------- request driver
   int          r_lat;
   logic        r_hit, r_err, r_acc, r_stall_bad, r_done_stall, r_fin;
   logic [15:0] r_dout;
   logic [15:0] st_addrs [$];

   task automatic preload(input logic [7:0] idx, input logic [4:0] tag, input logic dirty,
                          input logic [15:0] d0, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] d3);
      pl_idx = idx; pl_tag = tag; pl_dirty = dirty;
      pl_data[0] = d0; pl_data[1] = d1; pl_data[2] = d2; pl_data[3] = d3;
      pl_en = 1'b1;
      ref_mem[int'({tag, idx, 2'd0})] = d0;
      ref_mem[int'({tag, idx, 2'd1})] = d1;
      ref_mem[int'({tag, idx, 2'd2})] = d2;
      ref_mem[int'({tag, idx, 2'd3})] = d3;
      @(posedge clk); #1;
      pl_en = 1'b0; pl_mem_en = 1'b0;
   endtask

   // Starts just after a rising edge; cycle 0 is the request cycle.
   task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input int st_start, input int st_len);
      Rd = rd; Wr = wr; Addr = a; DataIn = d;
      r_lat = -1; r_hit = 1'b0; r_err = 1'b0; r_acc = 1'b0; r_dout = '0;
      r_stall_bad = 1'b0; r_done_stall = 1'b0; r_fin = 1'b0;
      st_addrs.delete();
      for (int c = 0; c < 80; c++) begin
         m_stall = (c >= st_start) && (c < st_start + st_len);
         @(negedge clk);
         if (Err) begin
            r_err = 1'b1; r_fin = 1'b1;
            r_acc = m_rd | m_wr | c_enable | Dmem_Stall | Done;
         end else if (Done) begin
            r_lat = c; r_hit = CacheHit; r_dout = DataOut;
            r_done_stall = Dmem_Stall; r_fin = 1'b1;
         end else begin
            if (!Dmem_Stall) r_stall_bad = 1'b1;
            if (m_stall) st_addrs.push_back(m_addr);
         end
         @(posedge clk); #1;
         if (r_fin) break;
      end
      Rd = 1'b0; Wr = 1'b0; m_stall = 1'b0;
      if (!r_fin) check_eq("timeout", 32'(r_fin), 32'd1);
   endtask

   // -------------------------------------------------------------- sequence
   logic [15:0] hd [4];
   logic [15:0] a;
   logic [15:0] d;
   logic        act;

   initial begin
      n_checks = 0; n_errors = 0;
      rst = 1'b0; Rd = 1'b1; Wr = 1'b0; Addr = 16'h0003; DataIn = 16'h0;
      m_stall = 1'b0; pl_en = 1'b0; pl_mem_en = 1'b0; env_clr = 1'b1;
      pl_idx = '0; pl_tag = '0; pl_dirty = 1'b0; pl_mem_a = '0; pl_mem_d = '0;
      for (int k = 0; k < 4; k++) pl_data[k] = '0;
      repeat (2) @(posedge clk);
      #1 env_clr = 1'b0;
      @(negedge clk);
      check_eq("reset_outputs", 32'(any_out()), 32'd0);
      @(posedge clk); #1;
      Rd = 1'b0; Addr = 16'h0; rst = 1'b1;
      @(posedge clk); #1;

      // Read hit: 0x0A2C decodes to tag 1, index 0x45, word 2.
      for (int k = 0; k < 4; k++) hd[k] = mem_rd({5'd1, 8'h45, 2'(k)});
      hd[2] = 16'hBEEF;
      pl_mem_en = 1'b1; pl_mem_a = {5'd1, 8'h45, 2'd2}; pl_mem_d = 16'hBEEF;
      preload(8'h45, 5'd1, 1'b0, hd[0], hd[1], hd[2], hd[3]);
      do_req(1'b1, 1'b0, 16'h0A2C, 16'h0, 99, 0);
      check_eq("hit_lat", r_lat, 0);
      check_eq("hit_flag", 32'(r_hit), 32'd1);
      check_eq("hit_data", 32'(r_dout), 32'hBEEF);
      check_eq("hit_nostall", 32'(r_done_stall), 32'd0);

      // Clean read miss.
      rd_log.delete();
      do_req(1'b1, 1'b0, 16'h1230, 16'h0, 99, 0);
      check_eq("clean_lat", r_lat, CLEAN_LAT);
      check_eq("clean_hit", 32'(r_hit), 32'd0);
      check_eq("clean_data", 32'(r_dout), 32'(ref_rd(16'h1230)));
      check_eq("clean_stall", 32'(r_stall_bad), 32'd0);
      check_eq("clean_nrd", rd_log.size(), 4);
      for (int k = 0; k < 4 && k < rd_log.size(); k++)
         check_eq("clean_rdaddr", 32'(rd_log[k]), 32'(16'h1230 + 16'(2 * k)));

      // Dirty write miss: victim tag 3, index 0x42.
      for (int k = 0; k < 4; k++) hd[k] = 16'($urandom);
      preload(8'h42, 5'd3, 1'b1, hd[0], hd[1], hd[2], hd[3]);
      rd_log.delete(); wr_log.delete();
      do_req(1'b0, 1'b1, 16'h4A10, 16'h1234, 99, 0);
      ref_mem[int'(15'h4A10 >> 1)] = 16'h1234;
      check_eq("dirty_lat", r_lat, DIRTY_LAT);
      check_eq("dirty_hit", 32'(r_hit), 32'd0);
      check_eq("dirty_nwr", wr_log.size(), 4);
      check_eq("dirty_nrd", rd_log.size(), 4);
      for (int k = 0; k < 4 && k < wr_log.size(); k++)
         check_eq("dirty_wb", wr_log[k], {16'h1A10 + 16'(2 * k), hd[k]});
      do_req(1'b1, 1'b0, 16'h4A10, 16'h0, 99, 0);
      check_eq("dirty_rehit_lat", r_lat, 0);
      check_eq("dirty_rehit_flag", 32'(r_hit), 32'd1);
      check_eq("dirty_rehit_data", 32'(r_dout), 32'h1234);

      // Memory stall for 3 cycles on ALLOC word 1 (cycle 2 of the miss).
      rd_log.delete();
      do_req(1'b1, 1'b0, 16'h2238, 16'h0, 2, 3);
      check_eq("stall_lat", r_lat, CLEAN_LAT + 3);
      check_eq("stall_data", 32'(r_dout), 32'(ref_rd(16'h2238)));
      check_eq("stall_nrd", rd_log.size(), 4);
      check_eq("stall_n", st_addrs.size(), 3);
      for (int k = 0; k < st_addrs.size(); k++)
         check_eq("stall_addr", 32'(st_addrs[k]), 32'h223A);

      // Illegal requests.
      do_req(1'b1, 1'b1, 16'h0010, 16'h0, 99, 0);
      check_eq("err_rdwr", 32'(r_err), 32'd1);
      check_eq("err_rdwr_acc", 32'(r_acc), 32'd0);
      do_req(1'b1, 1'b0, 16'h0003, 16'h0, 99, 0);
      check_eq("err_odd", 32'(r_err), 32'd1);
      check_eq("err_odd_acc", 32'(r_acc), 32'd0);

      // Reset in the middle of FILL.
      Rd = 1'b1; Wr = 1'b0; Addr = 16'h4400;
      repeat (5) begin @(posedge clk); #1; end
      #2 rst = 1'b0;
      #1 check_eq("rst_fill_outs", 32'(any_out()), 32'd0);
      act = 1'b0;
      repeat (3) begin
         @(negedge clk);
         act = act | c_enable | m_rd | m_wr;
      end
      check_eq("rst_hold_quiet", 32'(act), 32'd0);
      @(posedge clk); #1;
      Rd = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      do_req(1'b1, 1'b0, 16'h4408, 16'h0, 99, 0);
      check_eq("post_rst_lat", r_lat, CLEAN_LAT);
      check_eq("post_rst_data", 32'(r_dout), 32'(ref_rd(16'h4408)));

      // Randomized traffic over four indices with conflicting tags.
      for (int n = 0; n < 80; n++) begin
         logic [7:0] idx;
         logic [4:0] tg;
         logic       wr;
         logic       exp_hit;
         int         exp_lat;
         idx = 8'h10 + 8'($urandom_range(0, 3));
         tg  = 5'($urandom_range(0, 3));
         a   = {tg, idx, 2'($urandom_range(0, 3)), 1'b0};
         d   = 16'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 1) == 0) do_req(1'b1, 1'b1, a, d, 99, 0);
            else do_req(1'b0, 1'b1, a | 16'h1, d, 99, 0);
            check_eq("rnd_err", 32'({r_err, r_acc}), 32'd2);
         end else begin
            wr = ($urandom_range(0, 2) == 0);
            exp_hit = cv[idx] && (ct[idx] == tg);
            exp_lat = exp_hit ? 0 : ((cv[idx] && cd[idx]) ? DIRTY_LAT : CLEAN_LAT);
            do_req(!wr, wr, a, d, 99, 0);
            check_eq("rnd_lat", r_lat, exp_lat);
            check_eq("rnd_hit", 32'({r_hit, r_stall_bad}), 32'({exp_hit, 1'b0}));
            if (wr) ref_mem[int'(a[15:1])] = d;
            else check_eq("rnd_data", 32'(r_dout), 32'(ref_rd(a)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
